// File: rtl/edge_strobe_gen.sv
// Multi-channel edge-strobe generator: per-channel synchroniser, rise/fall/both
// edge detection with one-cycle strobes, and a shared-divisor divide-by-N strobe.

module edge_strobe_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                 clkIn,
  input  logic                 reset,
  input  logic                 sig_i,
  input  logic [1:0]           mode_i,
  input  logic [DIV_WIDTH-1:0] eff_div_i,
  output logic                 edge_o,
  output logic                 div_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   edge_q, div_q, div_d;
  logic                   rise, fall, qual;
  logic [DIV_WIDTH-1:0]   last_cnt;

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall     = ~sync_q[SYNC_STAGES-1] & prev_q;
  assign qual     = (mode_i[0] & rise) | (mode_i[1] & fall);
  assign last_cnt = eff_div_i - DIV_WIDTH'(1);

  // >= rather than == so a divisor lowered mid-count fires on the next edge
  always_comb begin
    cnt_d = cnt_q;
    div_d = 1'b0;
    if (qual) begin
      if (cnt_q >= last_cnt) begin
        div_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      edge_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
      edge_q <= qual;
      div_q  <= div_d;
    end
  end

  assign edge_o = edge_q;
  assign div_o  = div_q;
endmodule

module edge_strobe_gen #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                  clkIn,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sigIn,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic [CHANNELS-1:0]   edgePulse,
  output logic [CHANNELS-1:0]   divPulse
);
  logic [DIV_WIDTH-1:0] eff_div;

  // a zero divisor behaves as divide-by-one
  assign eff_div = (divisor == '0) ? DIV_WIDTH'(1) : divisor;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    edge_strobe_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .DIV_WIDTH  (DIV_WIDTH)
    ) u_lane (
      .clkIn    (clkIn),
      .reset    (reset),
      .sig_i    (sigIn[i]),
      .mode_i   (mode[2*i+1 -: 2]),
      .eff_div_i(eff_div),
      .edge_o   (edgePulse[i]),
      .div_o    (divPulse[i])
    );
  end
endmodule

// File: tb/tb_edge_strobe_gen.sv
// Randomized + directed bench for edge_strobe_gen, checked every cycle against a
// sample-history model plus literal expectations from hand-worked scenarios.

module tb_edge_strobe_gen;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0]   sigIn;
  logic [2*CH-1:0] mode;
  logic [DW-1:0]   divisor;
  logic [CH-1:0]   edgePulse, divPulse;

  edge_strobe_gen #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .DIV_WIDTH(DW)) dut (
    .clkIn    (clk),
    .reset    (reset),
    .sigIn    (sigIn),
    .mode     (mode),
    .divisor  (divisor),
    .edgePulse(edgePulse),
    .divPulse (divPulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hist[k] is the sigIn level sampled k edges ago (zeros across reset).
  // The strobe after edge m reflects the transition between samples m-SYNC-1 and m-SYNC.
  logic [CH-1:0] hist [0:SYNC+1];
  int            cnt  [CH];
  logic [CH-1:0] exp_e, exp_d;

  always @(posedge clk) begin
    int  eff;
    bit  r, f, q;
    started = 1'b1;
    if (reset) begin
      for (int k = 0; k <= SYNC + 1; k++) hist[k] = '0;
      for (int i = 0; i < CH; i++) cnt[i] = 0;
      exp_e = '0;
      exp_d = '0;
    end else begin
      for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sigIn;
      eff = (divisor == 0) ? 1 : int'(divisor);
      exp_e = '0;
      exp_d = '0;
      for (int i = 0; i < CH; i++) begin
        r = hist[SYNC][i] && !hist[SYNC+1][i];
        f = !hist[SYNC][i] && hist[SYNC+1][i];
        q = (mode[2*i] && r) || (mode[2*i+1] && f);
        if (q) begin
          exp_e[i] = 1'b1;
          if (cnt[i] >= eff - 1) begin
            exp_d[i] = 1'b1;
            cnt[i]   = 0;
          end else begin
            cnt[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_edgePulse", 32'(edgePulse), 32'(exp_e));
      chk("model_divPulse",  32'(divPulse),  32'(exp_d));
    end
  end

  int ce [CH];
  int cd [CH];

  task automatic clr();
    for (int i = 0; i < CH; i++) begin ce[i] = 0; cd[i] = 0; end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stepc(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        ce[i] += int'(edgePulse[i]);
        cd[i] += int'(divPulse[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; sigIn = '0; mode = '0; divisor = 8'd1;
    step(2);
    chk("reset_edge", 32'(edgePulse), 32'h0);
    chk("reset_div",  32'(divPulse),  32'h0);

    // first rise on channel 0, divisor 1
    reset = 1'b0; mode = 8'h55;
    step(6);
    chk("idle_edge", 32'(edgePulse), 32'h0);
    sigIn[0] = 1'b1;
    step(1);
    step(1);
    chk("lat_e1", 32'(edgePulse), 32'h0);
    step(1);
    chk("lat_e2_edge", 32'(edgePulse), 32'h1);
    chk("lat_e2_div",  32'(divPulse),  32'h1);
    step(1);
    chk("lat_e3_edge", 32'(edgePulse), 32'h0);

    // channel 1 both-edges, toggling every 5 cycles
    mode = 8'h5D;
    step(3);
    clr();
    repeat (6) begin sigIn[1] = ~sigIn[1]; stepc(5); end
    stepc(4);
    chk("both_ch1_cnt",   32'(ce[1]), 32'd6);
    chk("both_other_cnt", 32'(ce[0] + ce[2] + ce[3]), 32'd0);

    // channel 2 fall-only, divisor 3
    mode = 8'h20; divisor = 8'd3;
    sigIn[2] = 1'b1;
    step(5);
    clr();
    repeat (6) begin sigIn[2] = 1'b0; stepc(4); sigIn[2] = 1'b1; stepc(4); end
    stepc(4);
    chk("fall_ch2_edges", 32'(ce[2]), 32'd6);
    chk("fall_ch2_divs",  32'(cd[2]), 32'd2);

    // divisor 0 acts as 1, then divisor lowered mid-count
    mode = 8'h55; divisor = 8'd0;
    repeat (40) begin sigIn = CH'($urandom); step(1); end
    sigIn = '0;
    step(5);
    divisor = 8'd5;
    repeat (3) begin sigIn[0] = 1'b1; step(4); sigIn[0] = 1'b0; step(4); end
    divisor = 8'd2;
    clr();
    sigIn[0] = 1'b1; stepc(4);
    chk("lower_div_fire", 32'(cd[0]), 32'd1);
    chk("lower_div_edge", 32'(ce[0]), 32'd1);
    sigIn[0] = 1'b0; step(4);
    clr();
    sigIn[0] = 1'b1; stepc(4);
    chk("after_clear_nofire", 32'(cd[0]), 32'd0);

    // mid-count reset on channel 3
    divisor = 8'd3; sigIn = '0;
    step(5);
    sigIn[3] = 1'b1; step(4);
    sigIn[3] = 1'b0; step(4);
    sigIn[3] = 1'b1; step(1);
    reset = 1'b1; step(1);
    chk("mid_reset_edge", 32'(edgePulse), 32'h0);
    chk("mid_reset_div",  32'(divPulse),  32'h0);
    reset = 1'b0;
    step(2);
    chk("post_reset_quiet", 32'(edgePulse), 32'h0);
    step(1);
    chk("post_reset_rise", 32'(edgePulse), 32'h8);
    chk("post_reset_div",  32'(divPulse),  32'h0);
    repeat (3) begin sigIn[3] = 1'b0; step(4); sigIn[3] = 1'b1; step(4); end

    // channel 0 disabled through its rise, re-enabled with input held high
    mode = 8'h54; sigIn = '0;
    step(5);
    clr();
    sigIn[0] = 1'b1; stepc(5);
    mode = 8'h55; stepc(6);
    chk("mode_off_ch0", 32'(ce[0] + cd[0]), 32'd0);

    // randomized soak
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(2) == 0) sigIn[i] = ~sigIn[i];
      if ($urandom_range(29) == 0) mode = 8'($urandom);
      if ($urandom_range(19) == 0) divisor = 8'($urandom_range(6));
      reset = ($urandom_range(59) == 0);
      step(1);
    end
    reset = 1'b0;
    step(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_strobe_gen.md
# edge_strobe_gen

Parametrised multi-channel edge-strobe generator, the successor to the single-channel clock doubler. Each channel synchronises an asynchronous or slow input into the `clkIn` domain and detects its rising edges, falling edges, or both, under per-channel mode control. On each qualified edge it emits a one-cycle strobe. A programmable divider also emits a one-cycle strobe every N qualified edges. Processor-side blocks use these strobes as clock enables and event ticks instead of deriving gated clocks.

## Interface
- CHANNELS, 4, number of independent channels
- SYNC_STAGES, 2, synchroniser depth per channel (minimum 2)
- DIV_WIDTH, 8, width of the shared divisor and of each per-channel edge counter
- clkIn  input  1  single system clock; all logic updates on its rising edge
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- sigIn  input  CHANNELS  raw channel inputs; bit i belongs to channel i
- mode  input  2*CHANNELS  bits [2i+1:2i] select channel i: 00 off, 01 rise, 10 fall, 11 both
- divisor  input  DIV_WIDTH  qualified edges per divPulse, shared by all channels; 0 is treated as 1
- edgePulse  output  CHANNELS  one-cycle strobe per qualified edge
- divPulse  output  CHANNELS  one-cycle strobe on every divisor-th qualified edge

## Operation
- Per channel:
  - SYNC_STAGES-deep flop chain, then a `prev` flop, then edge detect on (sync_last, prev).
  - rise = sync_last & ~prev; fall = ~sync_last & prev.
  - qualified = (mode[0] & rise) | (mode[1] & fall).
- edgePulse[i] is a registered copy of qualified[i].
- Divider counter cnt[i] (DIV_WIDTH bits), evaluated on a qualified edge:
  - Let effDiv = max(divisor, 1).
  - If cnt >= effDiv-1: divPulse=1 and cnt=0.
  - Otherwise: cnt=cnt+1.
  - No qualified edge: cnt holds.
- The `>=` compare covers a divisor lowered mid-count: the next qualified edge fires and clears. No wrap past 2^DIV_WIDTH-1 is possible.
- Mode 00: no edgePulse or divPulse, but sync and prev keep tracking sigIn, and cnt holds.
  - A mode change takes effect on the next edge.
  - Re-enabling a channel does not produce a spurious pulse from history, because prev is current.
- Divisor is sampled every cycle with no latching.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- Reset:
  - Clears all sync flops, prev, cnt, edgePulse and divPulse to 0. This applies mid-operation, with no partial pulses after reset asserts.
  - After reset releases, a sigIn held high is seen as a rising edge.

## Timing
- Reset values: edgePulse=0 and divPulse=0 for all channels, on the edge where reset is sampled high.
- Latency, sigIn to edgePulse:
  - Edge 0 is the first clkIn edge that samples the new sigIn level.
  - edgePulse is high after edge SYNC_STAGES, for exactly one cycle.
  - divPulse, when due, rises in the same cycle as the edgePulse.
- Pulse width is always one cycle, regardless of how long sigIn holds its level.
- Input pulses shorter than one clkIn period may be missed; this is not required to be detected.
- Back-to-back toggles on consecutive sampling edges in mode 11 give edgePulse high on consecutive cycles.
- Throughput: one qualified edge per channel per cycle.

## Test plan
All scenarios use CHANNELS=4, SYNC_STAGES=2, DIV_WIDTH=8.
- Reset, then sigIn=0, mode=0x55 (all rise), divisor=1 → after any number of cycles, edgePulse=0 and divPulse=0; raise sigIn[0] before edge 0 → edgePulse=0001 and divPulse=0001 after edge 2 only.
- Channel 1 in mode 11, sigIn[1] toggling every 5 cycles → edgePulse[1] is one cycle wide, once per toggle, 2 cycles after each sampling edge; no pulses on other channels.
- Channel 2 in mode 10, divisor=3, six falling edges → six edgePulse[2] strobes, and divPulse[2] on the 3rd and 6th only.
- Divisor=0 → divPulse equals edgePulse on every qualified edge. Divisor=5 with cnt=3, then divisor changed to 2 → the next edge fires divPulse and cnt returns to 0.
- Reset asserted for 1 cycle while sigIn[3]=1 and the channel is mid-count → outputs are 0 on the reset edge and cnt is cleared; with mode rise, one edgePulse[3] appears 2 cycles after release.
- Mode 00 on channel 0 while sigIn[0] rises, then mode switched to 01 with sigIn[0] held high → no pulses at all on channel 0.
